// File: rtl/id_ex_elastic_stage_pkg.sv
// Shared definitions for the decode->execute elastic stage.
// Holds:
//   - the payload field layout (offsets and widths, LSB first);
//   - the NOP payload that is driven downstream as a bubble;
//   - the buffer state encoding.
package id_ex_elastic_stage_pkg;

    localparam int PAYLOAD_W = 160;

    // Payload layout, LSB first. Bits above ALUOP are spare padding.
    localparam int INST_OFF   = 0;
    localparam int INST_W     = 32;
    localparam int DSLOT_OFF  = 32;   // [0]=is_in_delayslot, [1]=next_inst_in_delayslot
    localparam int DSLOT_W    = 2;
    localparam int LINK_OFF   = 34;
    localparam int LINK_W     = 32;
    localparam int WREG_OFF   = 66;
    localparam int WD_OFF     = 67;
    localparam int WD_W       = 5;
    localparam int REG2_OFF   = 72;
    localparam int REG2_W     = 32;
    localparam int REG1_OFF   = 104;
    localparam int REG1_W     = 32;
    localparam int ALUSEL_OFF = 136;
    localparam int ALUSEL_W   = 3;
    localparam int ALUOP_OFF  = 139;
    localparam int ALUOP_W    = 8;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP = 8'h00;

    // NOP: aluop=NOP and wreg=0; every other field is zero.
    localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD =
        PAYLOAD_W'(ALUOP_NOP) << ALUOP_OFF;

    // Number of valid entries held by the buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/id_ex_elastic_stage_skid_buf.sv
// elastic_skid_buf: valid/ready handshake with a main entry and, when
// SKID=1, a second skid entry.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | nothing held; dn_valid=0
//   ST_ONE   | main entry valid and presented downstream
//   ST_TWO   | main and skid both valid; upstream is stalled
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop all held entries at the edge
//   up_valid/up_ready     upstream handshake, up_data payload
//   dn_valid/dn_ready     downstream handshake, dn_data = raw main entry
//   occupancy             number of valid entries (registered)
module elastic_skid_buf
    import id_ex_elastic_stage_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
);

    buf_state_e        state_q, state_d;
    logic              rdy_q;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              xfer_in, xfer_out;
    logic              load_main, load_skid, main_from_skid;

    assign dn_valid  = (state_q != ST_EMPTY);
    assign dn_data   = main_q;
    assign occupancy = state_q;
    // With the skid entry, ready is a flop; without it, ready looks through.
    assign up_ready  = (SKID != 0) ? rdy_q : (!dn_valid || dn_ready);

    assign xfer_in  = up_valid && up_ready;
    assign xfer_out = dn_valid && dn_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d   = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        load_main = 1'b1;
                    end else if (xfer_in && (SKID != 0)) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (xfer_out) begin
                        state_d        = ST_ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != ST_TWO);
        end
    end

    // Payload flops carry no reset; the state register alone decides validity.
    always_ff @(posedge clk) begin
        if (load_main) main_q <= main_from_skid ? skid_q : up_data;
        if (load_skid) skid_q <= up_data;
    end

endmodule

// File: rtl/id_ex_elastic_stage.sv
// id_ex_elastic_stage: decode->execute pipeline register with valid/ready
// handshake, optional skid entry, NOP bubble insertion and a saturating
// backpressure counter.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 kill all held entries (mispredict / exception)
//   up_valid/up_ready     decode handshake, up_data payload
//   dn_valid/dn_ready     execute handshake, dn_data payload (BUBBLE_VAL when idle)
//   occupancy             entries held: 0, 1 or 2
//   bp_cycles             cycles with dn_valid && !dn_ready, saturating
module id_ex_elastic_stage
    import id_ex_elastic_stage_pkg::*;
#(
    parameter int                DATA_W     = 160,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_PAYLOAD),
    parameter int                SKID       = 1,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cycles
);

    logic [DATA_W-1:0] main_data;
    logic [CNT_W-1:0]  bp_q;

    elastic_skid_buf #(
        .DATA_W (DATA_W),
        .SKID   (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_data   (main_data),
        .occupancy (occupancy)
    );

    // Execute never sees a stale payload: idle cycles carry the NOP bubble.
    assign dn_data = dn_valid ? main_data : BUBBLE_VAL;

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_q <= '0;
        end else if (dn_valid && !dn_ready && (bp_q != '1)) begin
            bp_q <= bp_q + CNT_W'(1);
        end
    end

    assign bp_cycles = bp_q;

endmodule
